// File: rtl/alu_op_issuer_pkg.sv
// Shared definitions for the ALU operation issuer.
//   - Default widths for operands, function code and the op counter.
//   - ALU function codes and the highest legal code.
//   - Issuer FSM state encoding.
package alu_op_issuer_pkg;

    localparam int DATA_W_DEF = 4;
    localparam int FUNC_W_DEF = 3;
    localparam int CNT_W_DEF  = 8;

    // ALU function codes
    localparam int FN_INC   = 0;
    localparam int FN_ADD   = 1;
    localparam int FN_ADDV  = 2;
    localparam int FN_XOROR = 3;
    localparam int FN_ANY   = 4;
    localparam int FN_CAT   = 5;

    // Codes above this are rejected by the issuer with rsp_err
    localparam int MAX_FUNC_CODE = FN_CAT;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_op_issuer_if.sv
// Bus bundle between the issuer and its environment.
//   req_*   : operation request handshake (front end -> issuer)
//   alu_*   : registered operands/function to the ALU, combinational result back
//   rsp_*   : result response handshake (issuer -> consumer)
// Modports:
//   slave  : the issuer itself
//   master : everything around it (front end, ALU and response consumer)
interface alu_op_issuer_if
    import alu_op_issuer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int FUNC_W = FUNC_W_DEF
);

    logic                  req_valid;
    logic                  req_ready;
    logic [DATA_W-1:0]     req_a;
    logic [DATA_W-1:0]     req_b;
    logic [FUNC_W-1:0]     req_func;
    logic                  req_use_acc;

    logic [DATA_W-1:0]     alu_a;
    logic [DATA_W-1:0]     alu_b;
    logic [FUNC_W-1:0]     alu_func;
    logic [2*DATA_W-1:0]   alu_result;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [2*DATA_W-1:0]   rsp_data;
    logic                  rsp_err;

    modport slave (
        input  req_valid, req_a, req_b, req_func, req_use_acc,
        input  alu_result,
        input  rsp_ready,
        output req_ready,
        output alu_a, alu_b, alu_func,
        output rsp_valid, rsp_data, rsp_err
    );

    modport master (
        output req_valid, req_a, req_b, req_func, req_use_acc,
        output alu_result,
        output rsp_ready,
        input  req_ready,
        input  alu_a, alu_b, alu_func,
        input  rsp_valid, rsp_data, rsp_err
    );

endinterface

// File: rtl/alu_op_issuer_sat_counter.sv
// Saturating up-counter used for the completed-operation display count.
//   clock   : rising-edge clock
//   resetn  : asynchronous active-low clear
//   enable  : advance by one this cycle (holds once all-ones is reached)
//   count   : current value
module alu_op_issuer_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             enable,
    output logic [CNT_W-1:0] count
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (enable) begin
            count <= sat_inc(count);
        end
    end

endmodule

// File: rtl/alu_op_issuer.sv
// Initiator side of the ALU operand/function interface.
// Takes one request at a time, drives registered A/B/func to the external
// ALU, captures its result after one settle cycle and returns it over a
// response handshake. An accumulator (last good result, low half) can stand
// in for operand A to chain operations; op_count counts handed-off responses.
// Ports:
//   clock     : rising-edge clock
//   resetn    : asynchronous active-low reset, aborts any operation in flight
//   bus       : request / ALU / response signals (slave modport)
//   op_count  : responses handed off, saturating
module alu_op_issuer
    import alu_op_issuer_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int FUNC_W   = FUNC_W_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int MAX_FUNC = MAX_FUNC_CODE
) (
    input  logic              clock,
    input  logic              resetn,
    alu_op_issuer_if.slave    bus,
    output logic [CNT_W-1:0]  op_count
);

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] acc;
    logic              accept;
    logic              handoff;
    logic              func_bad;

    assign accept   = (state == S_IDLE) && bus.req_valid;
    assign handoff  = (state == S_RESP) && bus.rsp_ready;
    assign func_bad = bus.alu_func > FUNC_W'(MAX_FUNC);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        case (state)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    state_nxt = S_EXEC;
                end
            end
            // ALU output settles on the freshly registered operands here
            S_EXEC: begin
                state_nxt = S_RESP;
            end
            S_RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Operands only change on acceptance so the ALU inputs stay glitch-free
    // and never follow req_* combinationally.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            bus.alu_a    <= '0;
            bus.alu_b    <= '0;
            bus.alu_func <= '0;
        end else if (accept) begin
            bus.alu_a    <= bus.req_use_acc ? acc : bus.req_a;
            bus.alu_b    <= bus.req_b;
            bus.alu_func <= bus.req_func;
        end
    end

    // Illegal codes return zero data rather than whatever the ALU produces.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            bus.rsp_data <= '0;
            bus.rsp_err  <= 1'b0;
        end else if (state == S_EXEC) begin
            if (func_bad) begin
                bus.rsp_data <= '0;
                bus.rsp_err  <= 1'b1;
            end else begin
                bus.rsp_data <= bus.alu_result;
                bus.rsp_err  <= 1'b0;
            end
        end
    end

    // Errored responses leave the accumulator untouched so a chain survives
    // a bad function code.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            acc <= '0;
        end else if (handoff && !bus.rsp_err) begin
            acc <= bus.rsp_data[DATA_W-1:0];
        end
    end

    alu_op_issuer_sat_counter #(
        .CNT_W (CNT_W)
    ) u_op_counter (
        .clock  (clock),
        .resetn (resetn),
        .enable (handoff),
        .count  (op_count)
    );

endmodule

// File: tb/tb_alu_op_issuer.sv
// Directed bench for alu_op_issuer paired with a behavioural 4-bit ALU.
// All stimulus is applied and all outputs sampled on the falling clock edge.
module tb_alu_op_issuer;

    logic       clock = 1'b0;
    logic       resetn;
    logic [7:0] op_count;
    int         checks = 0;
    int         errors = 0;

    always #5 clock = ~clock;

    alu_op_issuer_if #(.DATA_W(4), .FUNC_W(3)) bus ();

    alu_op_issuer #(
        .DATA_W   (4),
        .FUNC_W   (3),
        .CNT_W    (8),
        .MAX_FUNC (5)
    ) dut (
        .clock    (clock),
        .resetn   (resetn),
        .bus      (bus.slave),
        .op_count (op_count)
    );

    // External ALU: arithmetic results are {carry/flag, 3'b000, sum}.
    // Unused codes produce 8'hEE so a leaked ALU value is visible.
    function automatic logic [7:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                             input logic [2:0] f);
        logic [4:0] s;
        logic       ov;
        case (f)
            3'd0: begin s = {1'b0, a} + 5'd1;         return {s[4], 3'b000, s[3:0]}; end
            3'd1: begin s = {1'b0, a} + {1'b0, b};    return {s[4], 3'b000, s[3:0]}; end
            3'd2: begin
                s  = {1'b0, a} + {1'b0, b};
                ov = (a[3] == b[3]) && (s[3] != a[3]);
                return {ov, 3'b000, s[3:0]};
            end
            3'd3: return {a | b, a ^ b};
            3'd4: return {7'b0, |{a, b}};
            3'd5: return {a, b};
            default: return 8'hEE;
        endcase
    endfunction

    assign bus.alu_result = alu_model(bus.alu_a, bus.alu_b, bus.alu_func);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input logic [3:0] a, input logic [3:0] b, input logic [2:0] f,
                             input logic use_acc);
        bus.req_valid   = 1'b1;
        bus.req_a       = a;
        bus.req_b       = b;
        bus.req_func    = f;
        bus.req_use_acc = use_acc;
    endtask

    // Full checked operation. Entered and left on a falling edge with the DUT idle.
    task automatic op(input string tag, input logic [3:0] a, input logic [3:0] b,
                      input logic [2:0] f, input logic use_acc, input logic [3:0] exp_a,
                      input logic [7:0] exp_data, input logic exp_err);
        drive_req(a, b, f, use_acc);
        bus.rsp_ready = 1'b0;
        @(negedge clock);
        bus.req_valid = 1'b0;
        check({tag, ".alu_a"},     32'(bus.alu_a), 32'(exp_a));
        check({tag, ".alu_func"},  32'(bus.alu_func), 32'(f));
        check({tag, ".vld_c1"},    32'(bus.rsp_valid), 32'(0));
        check({tag, ".rdy_c1"},    32'(bus.req_ready), 32'(0));
        @(negedge clock);
        check({tag, ".vld_c2"},    32'(bus.rsp_valid), 32'(1));
        check({tag, ".data"},      32'(bus.rsp_data), 32'(exp_data));
        check({tag, ".err"},       32'(bus.rsp_err), 32'(exp_err));
        bus.rsp_ready = 1'b1;
        @(negedge clock);
        bus.rsp_ready = 1'b0;
        check({tag, ".vld_done"},  32'(bus.rsp_valid), 32'(0));
        check({tag, ".rdy_done"},  32'(bus.req_ready), 32'(1));
    endtask

    task automatic fast_op();
        drive_req(4'h1, 4'h2, 3'd5, 1'b0);
        @(negedge clock);
        bus.req_valid = 1'b0;
        @(negedge clock);
        bus.rsp_ready = 1'b1;
        @(negedge clock);
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        resetn          = 1'b0;
        bus.req_valid   = 1'b0;
        bus.req_a       = '0;
        bus.req_b       = '0;
        bus.req_func    = '0;
        bus.req_use_acc = 1'b0;
        bus.rsp_ready   = 1'b0;
        @(negedge clock);
        check("rst.req_ready", 32'(bus.req_ready), 32'(1));
        check("rst.rsp_valid", 32'(bus.rsp_valid), 32'(0));
        check("rst.rsp_err",   32'(bus.rsp_err), 32'(0));
        check("rst.rsp_data",  32'(bus.rsp_data), 32'(0));
        check("rst.alu_a",     32'(bus.alu_a), 32'(0));
        check("rst.alu_b",     32'(bus.alu_b), 32'(0));
        check("rst.alu_func",  32'(bus.alu_func), 32'(0));
        check("rst.op_count",  32'(op_count), 32'(0));
        resetn = 1'b1;
        @(negedge clock);

        op("inc7",   4'h7, 4'h0, 3'd0, 1'b0, 4'h7, 8'h08, 1'b0);
        op("incF",   4'hF, 4'h0, 3'd0, 1'b0, 4'hF, 8'h80, 1'b0);
        op("add98",  4'h9, 4'h8, 3'd1, 1'b0, 4'h9, 8'h81, 1'b0);
        op("xoror",  4'h5, 4'h3, 3'd3, 1'b0, 4'h5, 8'h76, 1'b0);
        op("cat",    4'h3, 4'hC, 3'd5, 1'b0, 4'h3, 8'h3C, 1'b0);
        op("accadd", 4'h2, 4'h1, 3'd1, 1'b1, 4'hC, 8'h0D, 1'b0);
        check("cnt6", 32'(op_count), 32'(6));

        op("bad6",   4'h2, 4'h2, 3'd6, 1'b0, 4'h2, 8'h00, 1'b1);
        check("cnt7", 32'(op_count), 32'(7));
        op("accinc", 4'h5, 4'h0, 3'd0, 1'b1, 4'hD, 8'h0E, 1'b0);

        // Response stalled for several cycles with a competing request present
        drive_req(4'h4, 4'h4, 3'd1, 1'b0);
        @(negedge clock);
        bus.req_valid = 1'b0;
        @(negedge clock);
        for (int i = 0; i < 5; i++) begin
            check("stall.vld",  32'(bus.rsp_valid), 32'(1));
            check("stall.data", 32'(bus.rsp_data), 32'(8'h08));
            check("stall.rdy",  32'(bus.req_ready), 32'(0));
            check("stall.a",    32'(bus.alu_a), 32'(4'h4));
            drive_req(4'h9, 4'h9, 3'd1, 1'b0);
            @(negedge clock);
        end
        check("stall.vld_end", 32'(bus.rsp_valid), 32'(1));
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clock);
        bus.rsp_ready = 1'b0;
        check("release.vld", 32'(bus.rsp_valid), 32'(0));
        check("release.rdy", 32'(bus.req_ready), 32'(1));
        check("release.a",   32'(bus.alu_a), 32'(4'h4));
        check("release.cnt", 32'(op_count), 32'(9));

        // Reset while the operation is in EXEC
        drive_req(4'h1, 4'h1, 3'd1, 1'b0);
        @(negedge clock);
        bus.req_valid = 1'b0;
        check("midrst.pre_a", 32'(bus.alu_a), 32'(4'h1));
        #2 resetn = 1'b0;
        #1;
        check("midrst.req_ready", 32'(bus.req_ready), 32'(1));
        check("midrst.rsp_valid", 32'(bus.rsp_valid), 32'(0));
        check("midrst.rsp_err",   32'(bus.rsp_err), 32'(0));
        check("midrst.rsp_data",  32'(bus.rsp_data), 32'(0));
        check("midrst.alu_a",     32'(bus.alu_a), 32'(0));
        check("midrst.alu_b",     32'(bus.alu_b), 32'(0));
        check("midrst.alu_func",  32'(bus.alu_func), 32'(0));
        check("midrst.op_count",  32'(op_count), 32'(0));
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check("postrst.vld", 32'(bus.rsp_valid), 32'(0));
        check("postrst.rdy", 32'(bus.req_ready), 32'(1));
        op("acc0", 4'h7, 4'h0, 3'd1, 1'b1, 4'h0, 8'h00, 1'b0);
        check("cnt1", 32'(op_count), 32'(1));

        // Counter saturation
        for (int i = 0; i < 253; i++) fast_op();
        check("cntFE", 32'(op_count), 32'(8'hFE));
        fast_op();
        check("cntFF", 32'(op_count), 32'(8'hFF));
        for (int i = 0; i < 5; i++) fast_op();
        check("cnt_sat", 32'(op_count), 32'(8'hFF));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
